// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the skid-buffered pipeline register.
//   DEFAULT_DATA_W : default datapath width (32 bits)
//   ST_EMPTY/BUSY/FULL : state codes. Bit 0 = main register valid,
//                        bit 1 = skid register valid.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

endpackage : pipe_pkg

// File: rtl/pipe_data_reg.sv
// ---------------------------------------------------------------------------
// pipe_data_reg
// DATA_W-wide data register with load enable and asynchronous active-high
// reset to zero. Used for both the main and the skid storage slots.
// Ports:
//   clk_i  : rising-edge clock
//   rst_i  : asynchronous active-high reset (clears the register)
//   load_i : capture d_i on the next rising edge
//   d_i    : data to capture
//   q_o    : registered data
// ---------------------------------------------------------------------------
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : pipe_data_reg

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry skid-buffered pipeline register (valid/ready on both sides).
// The downstream side may stall without any combinational path from
// out_ready to in_ready: in_ready is decoded straight from the state flops.
//
// Optional build macro: PIPE_SKID_FLUSH_EN
//   When defined, adds a synchronous active-high 'flush' input that empties
//   the buffer (state -> EMPTY) at the next edge, overriding any simultaneous
//   push or pop. Data registers keep their contents on flush.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   flush     : (PIPE_SKID_FLUSH_EN only) synchronous flush
//   in_data   : upstream word
//   in_valid  : upstream word present
//   in_ready  : buffer can accept a word this cycle (registered)
//   out_data  : word presented downstream (registered, main register)
//   out_valid : out_data holds a valid word (registered)
//   out_ready : downstream accepts out_data this cycle
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              main_load;
  logic              skid_load;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic              push;
  logic              pop;
  logic              flush_w;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // State bit 0 marks a valid main entry, bit 1 a valid skid entry, so both
  // handshake outputs are pure decodes of flops.
  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_data;

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d   = ST_BUSY;
          main_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (push && pop) begin
          main_load = 1'b1;
        end else if (push) begin
          // Downstream stalled: park the new word in the skid slot.
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the skid word can move forward.
        if (pop) begin
          state_d   = ST_BUSY;
          main_load = 1'b1;
          main_d    = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush discards everything, including a word offered this cycle;
    // loads are suppressed so out_data keeps its previous value.
    if (flush_w) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  pipe_data_reg #(
    .DATA_W (DATA_W)
  ) u_main_reg (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (out_data)
  );

  pipe_data_reg #(
    .DATA_W (DATA_W)
  ) u_skid_reg (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (skid_load),
    .d_i    (in_data),
    .q_o    (skid_q)
  );

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
// Scoreboard bench for pipe_skid_reg. Words are pushed to a queue when the
// bench offers them and the buffer has room (room is judged from the queue
// depth, not from the DUT), and popped when downstream takes the head.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush_tb;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  int total;
  int bad;
  int n_in;
  int n_out;
  logic         last_pushed;
  logic [W-1:0] last_head;
  logic [W-1:0] sb[$];

  pipe_skid_reg #(
    .DATA_W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush_tb),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // update the scoreboard for the coming rising edge, then return 1 time
  // unit after that edge so the caller can drive the next inputs.
  task automatic tick();
    logic popped;
    @(negedge clk);
    last_pushed = 1'b0;
    if (rst) begin
      sb.delete();
      last_head = '0;
    end else begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, (sb.size() > 0)});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (sb.size() < 2)});
      if (sb.size() > 0) begin
        chk("out_data", out_data, sb[0]);
        last_head = sb[0];
      end else begin
        chk("idle_data", out_data, last_head);
      end
      if (flush_tb) begin
        sb.delete();
      end else begin
        popped = out_ready && (sb.size() > 0);
        last_pushed = in_valid && (sb.size() < 2);
        if (popped) begin
          void'(sb.pop_front());
          n_out++;
        end
        if (last_pushed) begin
          sb.push_back(in_data);
          n_in++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("drain_empty", sb.size(), 0);
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    n_in = 0;
    n_out = 0;
    last_head = '0;
    last_pushed = 1'b0;
    rst = 1'b1;
    flush_tb = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    // Reset state
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'd0);

    // Streaming 1..8 at full rate
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = W'(i);
      tick();
    end
    drain();

    // Backpressure: 0xA, 0xB stall, 0xC offered while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_a", out_data, 32'hA);
    in_data = 32'hC;
    tick();
    tick();
    out_ready = 1'b1;
    while (!last_pushed && n_in < 100) tick();
    in_valid = 1'b0;
    drain();

    // Simultaneous push/pop while BUSY
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    in_data   = 32'h6;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pp_data", out_data, 32'h6);
    chk("pp_ready", {31'b0, in_ready}, 32'd1);
    tick();
    drain();

    // Asynchronous reset mid-stream while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_out_data", out_data, 32'd0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h33;
    tick();
    in_valid = 1'b0;
    chk("arst_first", out_data, 32'h33);
    tick();
    drain();

`ifdef PIPE_SKID_FLUSH_EN
    begin
      int out_before;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1;
      tick();
      in_data = 32'h2;
      tick();
      out_before = n_out;
      flush_tb  = 1'b1;
      in_data   = 32'h3;
      out_ready = 1'b1;
      tick();
      flush_tb = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_ready", {31'b0, in_ready}, 32'd1);
      tick();
      tick();
      chk("flush_no_out", n_out, out_before);
    end
`endif

    // Random valid/ready, 10000 incrementing words
    begin
      int start_in;
      int start_out;
      int cycles;
      logic [W-1:0] word;
      start_in  = n_in;
      start_out = n_out;
      word = 32'h1000;
      cycles = 0;
      while ((n_in - start_in) < 10000 && cycles < 60000) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
        in_data   = word;
        tick();
        if (last_pushed) word = word + 1;
        cycles++;
      end
      chk("rand_words_in", n_in - start_in, 10000);
      drain();
      chk("rand_words_out", n_out - start_out, 10000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_skid_reg
